stack_ctrl: RTL and testbench
=============================

# stack_ctrl

Sequencer sitting directly upstream of the 16-entry hardware stack. Accepts PUSH/POP requests from the control unit over a valid/ready handshake and drives the stack's level-sensitive `push`/`pop` strobes as single-cycle pulses separated by a mandatory low cycle. Captures popped data and returns one response beat per request. Tracks occupancy and flags overflow/underflow.

## Interface
- `DEPTH`, default 16: stack entries; must match the stack instance.
- `WIDTH`, default 16: data width.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in 1: request present.
- `req_op` in 1: 0 = PUSH, 1 = POP.
- `req_data` in WIDTH: PUSH payload; ignored for POP.
- `req_ready` out 1: high only in IDLE.
- `rsp_valid` out 1: response beat present; held until `rsp_ready`.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_data` out WIDTH: popped value; 0 for PUSH and error responses.
- `rsp_err` out 1: request rejected (overflow/underflow).
- `stk_push` out 1: to stack `push`.
- `stk_pop` out 1: to stack `pop`.
- `stk_data` out WIDTH: to stack `input1`.
- `stk_out` in WIDTH: from stack `out`.
- `depth` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `ovf_flag`, `udf_flag` out 1 each: sticky error flags, cleared only by `rst`.

## Operation
- States: IDLE, PUSH, POP, GAP, CAPT, RESP.
- IDLE: `req_ready`=1. On `req_valid`: latch op and data. The next state is:
  - PUSH, for a legal PUSH (`depth`<DEPTH).
  - POP, for a legal POP (`depth`>0).
  - RESP with `rsp_err`=1, for an illegal request (see Configuration).
- PUSH: `stk_push`=1, `stk_data`=latched data; `depth`+1 at cycle end; next GAP.
- GAP: both strobes 0; next RESP with `rsp_data`=0, `rsp_err`=0.
- POP: `stk_pop`=1; `depth`-1 at cycle end; next CAPT.
- CAPT: strobes 0; `rsp_data` <= `stk_out` at cycle end; next RESP.
- RESP: `rsp_valid`=1, outputs stable; on `rsp_ready` return to IDLE.
- Strobes are never high in consecutive cycles and never both high. `stk_data` holds its value for the whole PUSH cycle.
- Exactly one response per accepted request, in order.
- Error response: sets `ovf_flag` (PUSH at full) or `udf_flag` (POP at empty). No strobe is issued and `depth` is unchanged.

## Timing
- Reset values: state IDLE, `req_ready`=1 in the following cycle, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `stk_push`=0, `stk_pop`=0, `stk_data`=0, `depth`=0, `ovf_flag`=0, `udf_flag`=0.
- Legal request: accept edge, then `rsp_valid` 3 cycles later. Error request: `rsp_valid` 1 cycle after accept.
- Maximum throughput: one legal op per 4 cycles with `rsp_ready` tied high.
- `rsp_ready` high in the first RESP cycle permits a new accept 1 cycle later. Responses are not combinationally bypassed.
- `rst` mid-operation: strobes and `rsp_valid` drop at the next edge and `depth` returns to 0. The stack pointer is not reset by this block, so the system reasserts `rst` only together with a stack re-initialisation.

## Configuration
- `STACK_CTRL_GUARD_EN` defined: overflow/underflow checks active, as described above.
- `STACK_CTRL_GUARD_EN` undefined:
  - All requests are forwarded to the stack.
  - `depth` saturates at DEPTH and 0.
  - `rsp_err`, `ovf_flag` and `udf_flag` are tied 0.
  - POP at empty returns whatever `stk_out` presents.

## Test plan
- Reset, then PUSH 0x1234 then POP with `rsp_ready`=1:
  - `stk_push` pulses once with `stk_data`=0x1234.
  - POP response has `rsp_data`=0x1234 and `rsp_err`=0.
  - `depth` goes 0 -> 1 -> 0.
- PUSH 0x0001..0x0010, then 16 POPs: responses 0x0010 down to 0x0001, `depth` peaks at 16, strobes are never high in adjacent cycles.
- GUARD on, 16 PUSHes then a 17th PUSH 0xBEEF: response `rsp_err`=1 one cycle after accept, no `stk_push`, `ovf_flag`=1, `depth`=16.
- GUARD on, POP from reset: `rsp_err`=1, `rsp_data`=0, `udf_flag`=1, no `stk_pop`. A following PUSH/POP pair succeeds and `udf_flag` stays 1.
- Hold `rsp_ready`=0 for 5 cycles in RESP:
  - `rsp_valid`/`rsp_data` stable.
  - `req_ready`=0.
  - A second `req_valid` is not accepted until 1 cycle after the handshake.
- Assert `rst` during the POP state: `stk_pop` is 0 next cycle, `depth`=0, `rsp_valid` stays 0, `req_ready`=1.

Source files
------------

// File: rtl/stack_ctrl.sv
// Hardware-stack sequencer: valid/ready PUSH/POP requests become push/pop pulses with a gap cycle.
// Latency: the response is valid 3 cycles after a legal accept, or 1 cycle after a rejected one.
// Backpressure: a response is held until rsp_ready. Optional STACK_CTRL_GUARD_EN adds overflow/underflow rejection.
module stack_ctrl #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic                     req_op,
    input  logic [WIDTH-1:0]         req_data,
    output logic                     req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_err,
    output logic                     stk_push,
    output logic                     stk_pop,
    output logic [WIDTH-1:0]         stk_data,
    input  logic [WIDTH-1:0]         stk_out,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     ovf_flag,
    output logic                     udf_flag
);

    localparam int DW = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH,
        S_POP,
        S_GAP,
        S_CAPT,
        S_RESP
    } state_t;

    state_t state, next_state;
    logic   accept;
    logic   req_legal;
    logic   is_full;
    logic   is_empty;

    assign is_full  = (depth == DW'(DEPTH));
    assign is_empty = (depth == '0);

`ifdef STACK_CTRL_GUARD_EN
    assign req_legal = req_op ? !is_empty : !is_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_err  <= 1'b0;
            ovf_flag <= 1'b0;
            udf_flag <= 1'b0;
        end else if (accept) begin
            rsp_err <= !req_legal;
            if (!req_legal && !req_op) ovf_flag <= 1'b1;
            if (!req_legal &&  req_op) udf_flag <= 1'b1;
        end
    end
`else
    assign req_legal = 1'b1;
    assign rsp_err   = 1'b0;
    assign ovf_flag  = 1'b0;
    assign udf_flag  = 1'b0;
`endif

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (!req_legal)  next_state = S_RESP;
                    else if (req_op) next_state = S_POP;
                    else             next_state = S_PUSH;
                end
            end
            S_PUSH: begin
                stk_push   = 1'b1;
                next_state = S_GAP;
            end
            S_GAP:  next_state = S_RESP;
            S_POP: begin
                stk_pop    = 1'b1;
                next_state = S_CAPT;
            end
            S_CAPT: next_state = S_RESP;
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            stk_data <= '0;
            rsp_data <= '0;
            depth    <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                rsp_data <= '0;
                if (!req_op) stk_data <= req_data;
            end
            // The stack registers the popped word on the POP edge, so it is sampled one cycle later.
            if (state == S_CAPT) rsp_data <= stk_out;
            if (state == S_PUSH && !is_full)  depth <= depth + DW'(1);
            if (state == S_POP  && !is_empty) depth <= depth - DW'(1);
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Randomised bench for stack_ctrl: a transaction-level queue model predicts per-cycle outputs and a compare process checks them.
module tb_stack_ctrl;

    localparam int W = 16;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_op = 1'b0;
    logic [W-1:0] req_data = '0;
    logic         req_ready;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_data;
    logic         rsp_err;
    logic         stk_push;
    logic         stk_pop;
    logic [W-1:0] stk_data;
    logic [W-1:0] stk_out;
    logic [4:0]   depth;
    logic         ovf_flag;
    logic         udf_flag;

    stack_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_data(stk_data), .stk_out(stk_out),
        .depth(depth), .ovf_flag(ovf_flag), .udf_flag(udf_flag)
    );

    always #5 clk = ~clk;

    // Stack environment: drops pushes when full, presents 0xDEAD on a pop from empty.
    logic [W-1:0] smem [D];
    int           sp = 0;
    logic [W-1:0] sout = '0;
    always @(posedge clk) begin
        if (rst) begin
            sp   <= 0;
            sout <= '0;
        end else if (stk_push === 1'b1) begin
            if (sp < D) begin
                smem[sp] <= stk_data;
                sp       <= sp + 1;
            end
        end else if (stk_pop === 1'b1) begin
            if (sp > 0) begin
                sout <= smem[sp-1];
                sp   <= sp - 1;
            end else begin
                sout <= 16'hDEAD;
            end
        end
    end
    assign stk_out = sout;

    typedef struct {
        logic         push;
        logic         pop;
        logic [W-1:0] sdat;
        logic         rdy;
        logic         vld;
        logic [W-1:0] rdat;
        logic         rerr;
        int           dep;
        logic         ovf;
        logic         udf;
    } exp_t;

    exp_t         expq[$];
    logic [W-1:0] mq[$];
    logic         m_ovf = 1'b0;
    logic         m_udf = 1'b0;
    int           vectors = 0;
    int           miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    exp_t ce;
    logic prev_strobe = 1'b0;
    initial forever begin
        @(negedge clk);
        #1;
        if (expq.size() > 0) begin
            ce = expq.pop_front();
            chk("stk_push",  32'(stk_push),  32'(ce.push));
            chk("stk_pop",   32'(stk_pop),   32'(ce.pop));
            if (ce.push) chk("stk_data", 32'(stk_data), 32'(ce.sdat));
            chk("req_ready", 32'(req_ready), 32'(ce.rdy));
            chk("rsp_valid", 32'(rsp_valid), 32'(ce.vld));
            chk("depth",     32'(depth),     32'(ce.dep));
            chk("ovf_flag",  32'(ovf_flag),  32'(ce.ovf));
            chk("udf_flag",  32'(udf_flag),  32'(ce.udf));
            if (ce.vld) begin
                chk("rsp_data", 32'(rsp_data), 32'(ce.rdat));
                chk("rsp_err",  32'(rsp_err),  32'(ce.rerr));
            end
            chk("strobe_spacing",
                32'(((stk_push | stk_pop) & prev_strobe) | (stk_push & stk_pop)), 32'(0));
        end
        prev_strobe = (stk_push === 1'b1) || (stk_pop === 1'b1);
    end

    function automatic exp_t base();
        exp_t e;
        e.push = 1'b0; e.pop = 1'b0; e.sdat = '0; e.rdy = 1'b0; e.vld = 1'b0;
        e.rdat = '0; e.rerr = 1'b0; e.dep = mq.size(); e.ovf = m_ovf; e.udf = m_udf;
        return e;
    endfunction

    task automatic step(input exp_t e);
        expq.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        exp_t e;
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            e = base(); e.rdy = 1'b1; step(e);
        end
    endtask

    task automatic txn(input bit op, input logic [W-1:0] d, input int hold, input bit poke,
                       output logic [W-1:0] got);
        exp_t         e;
        bit           legal;
        bit           err = 1'b0;
        logic [W-1:0] rd = '0;
        req_valid = 1'b1; req_op = op; req_data = d; rsp_ready = 1'($urandom);
        e = base(); e.rdy = 1'b1; step(e);
        req_valid = 1'b0; req_data = W'($urandom);
`ifdef STACK_CTRL_GUARD_EN
        legal = op ? (mq.size() > 0) : (mq.size() < D);
`else
        legal = 1'b1;
`endif
        if (!legal) begin
            err = 1'b1;
            if (op) m_udf = 1'b1; else m_ovf = 1'b1;
        end else if (!op) begin
            e = base(); e.push = 1'b1; e.sdat = d; step(e);
            if (mq.size() < D) mq.push_back(d);
            e = base(); step(e);
        end else begin
            e = base(); e.pop = 1'b1; step(e);
            if (mq.size() > 0) rd = mq.pop_back(); else rd = 16'hDEAD;
            e = base(); step(e);
        end
        for (int i = 0; i <= hold; i++) begin
            rsp_ready = (i == hold); req_valid = poke; req_op = 1'($urandom); req_data = W'($urandom);
            e = base(); e.vld = 1'b1; e.rdat = rd; e.rerr = err;
            expq.push_back(e);
            #1;
            if (i == 0) got = rsp_data;
            @(negedge clk);
        end
        req_valid = 1'b0; rsp_ready = 1'b0;
    endtask

    task automatic reset_in_pop();
        exp_t e;
        req_valid = 1'b1; req_op = 1'b1; req_data = '0;
        e = base(); e.rdy = 1'b1; step(e);
        req_valid = 1'b0; rst = 1'b1;
        e = base(); e.pop = 1'b1; step(e);
        rst = 1'b0; mq.delete(); m_ovf = 1'b0; m_udf = 1'b0;
        chk("rst_mid_pop", 32'(stk_pop), 32'(0));
        chk("rst_mid_depth", 32'(depth), 32'(0));
        e = base(); e.rdy = 1'b1; step(e);
    endtask

    logic [W-1:0] got;
    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_rsp_data", 32'(rsp_data), 32'(0));
        chk("reset_stk_data", 32'(stk_data), 32'(0));
        chk("reset_rsp_err",  32'(rsp_err),  32'(0));
        chk("reset_depth",    32'(depth),    32'(0));
        chk("reset_req_ready",32'(req_ready),32'(1));
        idle(2);

        txn(1'b1, '0, 0, 1'b0, got);
`ifdef STACK_CTRL_GUARD_EN
        chk("udf_rsp_data", 32'(got), 32'(0));
        chk("udf_flag_set", 32'(udf_flag), 32'(1));
`else
        chk("empty_pop_data", 32'(got), 32'h0000DEAD);
`endif
        txn(1'b0, 16'h1234, 0, 1'b0, got);
        txn(1'b1, '0, 0, 1'b0, got);
        chk("pop_1234", 32'(got), 32'h00001234);

        for (int i = 1; i <= 16; i++) txn(1'b0, W'(i), $urandom_range(0, 1), 1'b0, got);
        chk("depth_full", 32'(depth), 32'(16));
        txn(1'b0, 16'hBEEF, 0, 1'b0, got);
        chk("depth_after_17th", 32'(depth), 32'(16));
`ifdef STACK_CTRL_GUARD_EN
        chk("ovf_flag_set", 32'(ovf_flag), 32'(1));
`endif
        for (int i = 0; i < 16; i++) begin
            txn(1'b1, '0, $urandom_range(0, 1), 1'b0, got);
            if (i == 0)  chk("lifo_first", 32'(got), 32'h00000010);
            if (i == 15) chk("lifo_last",  32'(got), 32'h00000001);
        end

        txn(1'b0, 16'h5A5A, 5, 1'b1, got);
        idle(1);
        txn(1'b1, '0, 0, 1'b1, got);
        chk("pop_after_hold", 32'(got), 32'h00005A5A);

        txn(1'b0, 16'h0077, 0, 1'b0, got);
        reset_in_pop();
        idle(1);

        for (int n = 0; n < 300; n++) begin
            bit op;
            if ((n / 40) % 2 == 0) op = ($urandom_range(0, 9) < 3);
            else                   op = ($urandom_range(0, 9) < 7);
            txn(op, W'($urandom), $urandom_range(0, 3), 1'($urandom), got);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        idle(2);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
